// File: rtl/calc_alu_seq_if.sv
// Handshake/data bundle between the opcode decoder, calc_alu_seq and the display formatter.
interface calc_alu_seq_if #(
  parameter int unsigned OPCODE_LENGTH = 5,
  parameter int unsigned RESULT_WIDTH  = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [OPCODE_LENGTH-1:0] opcode;
  logic [RESULT_WIDTH-1:0]  num_a;
  logic [RESULT_WIDTH-1:0]  num_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [RESULT_WIDTH-1:0]  num_c;
  logic                     err;
  logic [RESULT_WIDTH-1:0]  mem_value;

  modport master (
    output in_valid, opcode, num_a, num_b, out_ready,
    input  in_ready, out_valid, num_c, err, mem_value
  );

  modport slave (
    input  in_valid, opcode, num_a, num_b, out_ready,
    output in_ready, out_valid, num_c, err, mem_value
  );
endinterface

// File: rtl/calc_alu_seq.sv
// Sequential calculator ALU: 1-cycle arithmetic/memory ops, iterative divide/modulo/sqrt.
// Define CALC_ALU_SAT_EN to saturate add/sub/mul/square/cube/M+/M- instead of wrapping.
module calc_alu_seq #(
  parameter int unsigned OPCODE_LENGTH = 5,
  parameter int unsigned RESULT_WIDTH  = 32
) (
  input logic            clk,
  input logic            rst,
  calc_alu_seq_if.slave  bus
);
  localparam int unsigned W  = RESULT_WIDTH;
  localparam int unsigned CW = $clog2(RESULT_WIDTH);
`ifdef CALC_ALU_SAT_EN
  localparam int unsigned XW = 3 * W;
`else
  localparam int unsigned XW = W;
`endif

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_SQR  = 5'b00100;
  localparam logic [4:0] OP_CUBE = 5'b00101;
  localparam logic [4:0] OP_SQRT = 5'b00110;
  localparam logic [4:0] OP_POW2 = 5'b00111;
  localparam logic [4:0] OP_MOD  = 5'b01011;
  localparam logic [4:0] OP_PI   = 5'b01111;
  localparam logic [4:0] OP_MADD = 5'b10001;
  localparam logic [4:0] OP_MSUB = 5'b10010;
  localparam logic [4:0] OP_MR   = 5'b10100;
  localparam logic [4:0] OP_MC   = 5'b11000;

  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nxt;
  logic           in_ready_q, out_valid_q;
  logic           is_sqrt, is_sqrt_nxt, is_mod, is_mod_nxt;
  logic           neg_q, neg_q_nxt, neg_r, neg_r_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [W:0]     acc_r, acc_r_nxt;
  logic [W-1:0]   acc_q, acc_q_nxt;
  logic [W-1:0]   dvs, dvs_nxt;
  logic [W-1:0]   num_c_q, num_c_nxt;
  logic           err_q, err_nxt;
  logic [W-1:0]   mem_q, mem_nxt;

  logic signed [W-1:0]  a_s, b_s, mem_s;
  logic signed [XW-1:0] a_x, b_x, m_x;
  logic [4:0]           op5;
  logic                 accept;
  logic [W-1:0]         sc_res, sc_mem;
  logic                 sc_err;
  logic [W:0]           d_diff, s_t, s_r;
  logic [W-1:0]         d_rem, d_quo, s_q;

  assign a_s    = bus.num_a;
  assign b_s    = bus.num_b;
  assign mem_s  = mem_q;
  assign op5    = bus.opcode[4:0];
  assign accept = bus.in_valid && in_ready_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.num_c     = num_c_q;
  assign bus.err       = err_q;
  assign bus.mem_value = mem_q;

  // Returns {err, value}: clamp to the signed range when saturating, otherwise plain wrap.
  function automatic logic [W:0] fit(input logic signed [XW-1:0] v);
`ifdef CALC_ALU_SAT_EN
    if (v > XW'(SMAX)) return {1'b1, SMAX};
    if (v < XW'(SMIN)) return {1'b1, SMIN};
    return {1'b0, v[W-1:0]};
`else
    return {1'b0, v};
`endif
  endfunction

  // Single-cycle result, also covering the error exits of the iterative ops.
  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    sc_mem = mem_q;
    a_x    = XW'(a_s);
    b_x    = XW'(b_s);
    m_x    = XW'(mem_s);
    case (op5)
      OP_ADD:  {sc_err, sc_res} = fit(a_x + b_x);
      OP_SUB:  {sc_err, sc_res} = fit(a_x - b_x);
      OP_MUL:  {sc_err, sc_res} = fit(a_x * b_x);
      OP_SQR:  {sc_err, sc_res} = fit(a_x * a_x);
      OP_CUBE: {sc_err, sc_res} = fit(a_x * a_x * a_x);
      OP_POW2: begin
        if (!a_s[W-1] && bus.num_a <= W'(RESULT_WIDTH - 2)) sc_res = W'(1) << bus.num_a;
        else sc_err = 1'b1;
      end
      OP_PI:   sc_res = W'(3);
      OP_MADD: begin
        {sc_err, sc_res} = fit(m_x + a_x);
        sc_mem = sc_res;
      end
      OP_MSUB: begin
        {sc_err, sc_res} = fit(m_x - a_x);
        sc_mem = sc_res;
      end
      OP_MR:   sc_res = mem_q;
      OP_MC:   sc_mem = '0;
      default: sc_err = 1'b1;
    endcase
  end

  // Next-state, iteration datapath and result capture.
  always_comb begin
    state_nxt   = state;
    is_sqrt_nxt = is_sqrt;
    is_mod_nxt  = is_mod;
    neg_q_nxt   = neg_q;
    neg_r_nxt   = neg_r;
    cnt_nxt     = cnt;
    acc_r_nxt   = acc_r;
    acc_q_nxt   = acc_q;
    dvs_nxt     = dvs;
    num_c_nxt   = num_c_q;
    err_nxt     = err_q;
    mem_nxt     = mem_q;

    // Restoring division: shift in the next dividend bit, keep the difference if non-negative.
    d_diff = {acc_r[W-1:0], acc_q[W-1]} - {1'b0, dvs};
    d_rem  = d_diff[W] ? {acc_r[W-2:0], acc_q[W-1]} : d_diff[W-1:0];
    d_quo  = {acc_q[W-2:0], ~d_diff[W]};
    // Non-restoring sqrt: bring down two radicand bits, add or subtract by remainder sign.
    s_t = {acc_r[W-2:0], acc_q[W-1:W-2]};
    s_r = acc_r[W] ? s_t + {dvs[W-2:0], 2'b11} : s_t - {dvs[W-2:0], 2'b01};
    s_q = {dvs[W-2:0], ~s_r[W]};

    case (state)
      IDLE: begin
        if (accept) begin
          is_sqrt_nxt = (op5 == OP_SQRT);
          is_mod_nxt  = (op5 == OP_MOD);
          if ((op5 == OP_DIV || op5 == OP_MOD) && bus.num_b != '0) begin
            state_nxt = BUSY;
            acc_r_nxt = '0;
            acc_q_nxt = a_s[W-1] ? -bus.num_a : bus.num_a;
            dvs_nxt   = b_s[W-1] ? -bus.num_b : bus.num_b;
            neg_q_nxt = a_s[W-1] ^ b_s[W-1];
            neg_r_nxt = a_s[W-1];
            cnt_nxt   = CW'(W - 1);
          end else if (op5 == OP_SQRT && !a_s[W-1]) begin
            state_nxt = BUSY;
            acc_r_nxt = '0;
            acc_q_nxt = bus.num_a;
            dvs_nxt   = '0;
            cnt_nxt   = CW'(W / 2 - 1);
          end else begin
            state_nxt = DONE;
            num_c_nxt = sc_res;
            err_nxt   = sc_err;
            mem_nxt   = sc_mem;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (is_sqrt) begin
          acc_r_nxt = s_r;
          acc_q_nxt = {acc_q[W-3:0], 2'b00};
          dvs_nxt   = s_q;
        end else begin
          acc_r_nxt = {1'b0, d_rem};
          acc_q_nxt = d_quo;
        end
        if (cnt == '0) begin
          state_nxt = DONE;
          err_nxt   = 1'b0;
          if (is_sqrt)     num_c_nxt = s_q;
          else if (is_mod) num_c_nxt = neg_r ? -d_rem : d_rem;
          else             num_c_nxt = neg_q ? -d_quo : d_quo;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      is_sqrt     <= 1'b0;
      is_mod      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      cnt         <= '0;
      acc_r       <= '0;
      acc_q       <= '0;
      dvs         <= '0;
      num_c_q     <= '0;
      err_q       <= 1'b0;
      mem_q       <= '0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      out_valid_q <= (state_nxt == DONE);
      is_sqrt     <= is_sqrt_nxt;
      is_mod      <= is_mod_nxt;
      neg_q       <= neg_q_nxt;
      neg_r       <= neg_r_nxt;
      cnt         <= cnt_nxt;
      acc_r       <= acc_r_nxt;
      acc_q       <= acc_q_nxt;
      dvs         <= dvs_nxt;
      num_c_q     <= num_c_nxt;
      err_q       <= err_nxt;
      mem_q       <= mem_nxt;
    end
  end
endmodule
